skinny_tbc_iter: RTL and testbench
==================================

Name: skinny_tbc_iter

Overview:
Iterative Skinny-128-384 tweakable-block-cipher core for the Romulus datapath.
- Registers the cipher state, TK1 (counter), TK2 (tweak) and TK3 (key).
- Each cycle, feeds these registers through one instance of the unrolled round function `skinny_rnd`, which computes NUMRND rounds combinationally.
- Generates the round constants from a 6-bit LFSR and counts iterations.
- Presents the ciphertext on a valid/ready output handshake. Sits directly upstream of, and around, `skinny_rnd`.

Parameters:
- NUMRND, 2: rounds computed per clock; passed to `skinny_rnd.numrnd`.
- TOTRND, 40: total rounds; 40 for Skinny-128-384+, 56 for classic Skinny.
- FULLCNT, 1: passed to `skinny_rnd.fullcnt`. 1 means TK1 is 128 bits; 0 means 64 bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- in_valid  in  1  input block valid
- in_ready  out  1  core accepts input
- pt  in  128  plaintext; byte 0 in [127:120]
- tk1  in  64+64*FULLCNT  TK1 / counter
- tk2  in  128  TK2 / tweak
- tk3  in  128  TK3 / key
- out_valid  out  1  ct valid
- out_ready  in  1  consumer accepts ct
- ct  out  128  ciphertext

Behaviour:
- Reset and clocking: one clock (clk). rst_n is synchronous, active low, and sampled on the rising edge of clk.
- Reset state: FSM=IDLE, in_ready=1, out_valid=0, ct=0, all data registers 0, iteration counter 0, rc_reg=6'h01.
- Reset mid-operation: any RUN or DONE activity is abandoned. The next cycle is IDLE with the reset values above; no ct is emitted.
- Elaboration: TOTRND % NUMRND != 0 is an elaboration error. Define ITER = TOTRND/NUMRND.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, load state<=pt, tk1/tk2/tk3 registers <= inputs, rc_reg<=6'h01, cnt<=0, and go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Every cycle: state/key/tweak/cnt registers <= `skinny_rnd` nextstate/nextkey/nexttweak/nextcnt; iteration counter +1.
  - When the counter equals ITER-1, go to DONE.
- DONE:
  - out_valid=1; ct = state register, held stable while out_ready=0.
  - On out_ready, go to IDLE. out_valid is 0 on the following cycle.
  - in_ready=0 in DONE, so no input is accepted in the same cycle as the output handshake.
- Latency: the accept edge to the first out_valid=1 cycle is exactly ITER+1 cycles. Throughput is one block per ITER+2 cycles with out_ready held at 1.
- Round constant LFSR:
  - step(rc) = {rc[4:0], rc[5]^rc[4]^1'b1}.
  - rc_reg holds the constant of the next round to execute.
  - Constant lane i (bits 6i+5:6i) driven to `skinny_rnd` = step^i(rc_reg), for i = 0..NUMRND-1.
  - In RUN, rc_reg <= step^NUMRND(rc_reg).
  - The sequence starts 01,03,07,0F,1F,3E,3D,3B,...
- Iteration counter: width clog2(ITER), no wrap beyond ITER-1.
- The `skinny_rnd` input ports are driven straight from the registers. There is no combinational path from in_* to out_* or to ct.

Decomposition:
- Package `skinny_pkg`:
  - FSM state enum (IDLE/RUN/DONE).
  - Constant RC_INIT=6'h01.
  - Function rc_step(6-bit).
  - Localparam helper for ITER and the counter width.
- Sub-module: one `skinny_rnd` instance (datapath). The LFSR is inline logic in this block, not a separate module.

Test Plan:
1. TOTRND=56, NUMRND=2, FULLCNT=1; load the Skinny-128-384 spec vector:
   - tk1=df889548cfc7ea52d296339301797449
   - tk2=ab588a34a47f1ab2dfe9c8293fbea9a5
   - tk3=ab1afac2611012cd8cef952618c3ebe8
   - pt=a3994b66ad85a3459f44e92b08f550cb
   - Required: ct=94ecf589e2017c601b38c6346a10dcfa, out_valid rising exactly 29 cycles after accept.
2. Same vector with NUMRND=1 -> identical ct, latency 57 cycles. Then TOTRND=40 -> latency 21 cycles (NUMRND=2).
3. Constant bus check, NUMRND=2:
   - First RUN cycle shows constant={6'h03,6'h01}.
   - Second RUN cycle shows {6'h0F,6'h07}.
   - Third RUN cycle shows {6'h3E,6'h1F}.
4. Hold out_ready=0 for 10 cycles in DONE -> out_valid=1 and ct stable throughout; in_ready=0 and pulses on in_valid ignored. Release out_ready -> IDLE, in_ready=1 next cycle.
5. Assert in_valid with a different pt during RUN -> result still equals the first block's ct.
6. Pull rst_n low for one cycle mid-RUN, and separately during DONE -> next cycle out_valid=0, ct=0, in_ready=1. A fresh block then produces the correct ct.

Source files
------------

// File: rtl/skinny_pkg.sv
// Shared types and helpers for the iterative Skinny-128-384 core:
// FSM encoding, round-constant LFSR step and iteration sizing.
package skinny_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  localparam logic [5:0] RC_INIT = 6'h01;

  // One step of the 6-bit round-constant LFSR.
  function automatic logic [5:0] rc_step(input logic [5:0] rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction

  function automatic int iter_of(input int totrnd, input int numrnd);
    return totrnd / numrnd;
  endfunction

  function automatic int cnt_width(input int iter);
    return (iter > 1) ? $clog2(iter) : 1;
  endfunction

endpackage

// File: rtl/skinny_tbc_iter_rnd.sv
// Combinational Skinny-128-384 datapath: numrnd unrolled rounds plus the
// matching TK1/TK2/TK3 schedule updates.
module skinny_rnd #(
  parameter int numrnd  = 2,
  parameter int fullcnt = 1
) (
  input  logic [127:0]            i_state,
  input  logic [127:0]            i_key,
  input  logic [127:0]            i_tweak,
  input  logic [63+64*fullcnt:0]  i_cnt,
  input  logic [6*numrnd-1:0]     i_const,
  output logic [127:0]            o_nextstate,
  output logic [127:0]            o_nextkey,
  output logic [127:0]            o_nexttweak,
  output logic [63+64*fullcnt:0]  o_nextcnt
);

  localparam int PT [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};

  function automatic logic [7:0] sb_mix(input logic [7:0] x);
    return x ^ {3'b000, ~(x[7] | x[6]), 3'b000, ~(x[3] | x[2])};
  endfunction

  function automatic logic [7:0] sb_perm(input logic [7:0] x);
    return {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
  endfunction

  // 8-bit S-box built from its NOR/XOR network instead of a 256-entry table.
  function automatic logic [7:0] sbox8(input logic [7:0] x);
    logic [7:0] y;
    y = x;
    for (int r = 0; r < 3; r++) y = sb_perm(sb_mix(y));
    y = sb_mix(y);
    return {y[7:3], y[1], y[2], y[0]};
  endfunction

  function automatic logic [127:0] round_state(input logic [127:0] s,
                                               input logic [127:0] tk,
                                               input logic [5:0]   rc);
    logic [7:0]   c [16];
    logic [7:0]   r [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) c[i] = sbox8(s[127-8*i -: 8]);
    c[0] = c[0] ^ {4'h0, rc[3:0]};
    c[4] = c[4] ^ {6'h00, rc[5:4]};
    c[8] = c[8] ^ 8'h02;
    for (int i = 0; i < 8; i++) c[i] = c[i] ^ tk[127-8*i -: 8];
    // ShiftRows rotates row n right by n cells.
    for (int i = 0; i < 16; i++) r[i] = c[(i & 12) | (((i & 3) - (i >> 2)) & 3)];
    o = '0;
    for (int j = 0; j < 4; j++) begin
      o[127-8*j -: 8]      = r[j] ^ r[8+j] ^ r[12+j];
      o[127-8*(4+j) -: 8]  = r[j];
      o[127-8*(8+j) -: 8]  = r[4+j] ^ r[8+j];
      o[127-8*(12+j) -: 8] = r[j] ^ r[8+j];
    end
    return o;
  endfunction

  // Cell permutation, then the per-lane LFSR on the top two rows (2=TK2, 3=TK3).
  function automatic logic [127:0] tk_next(input logic [127:0] t, input int lfsr);
    logic [127:0] o;
    logic [7:0]   b;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      b = t[127-8*PT[i] -: 8];
      if (i < 8 && lfsr == 2)      b = {b[6:0], b[7] ^ b[5]};
      else if (i < 8 && lfsr == 3) b = {b[0] ^ b[6], b[7:1]};
      o[127-8*i -: 8] = b;
    end
    return o;
  endfunction

  logic [127:0] w_s  [numrnd+1];
  logic [127:0] w_k1 [numrnd+1];
  logic [127:0] w_k2 [numrnd+1];
  logic [127:0] w_k3 [numrnd+1];

  assign w_s[0]  = i_state;
  assign w_k2[0] = i_tweak;
  assign w_k3[0] = i_key;

  // A 64-bit TK1 occupies the top two rows; the lower half stays zero over an even round count.
  if (fullcnt != 0) begin : g_tk1_full
    assign w_k1[0] = i_cnt;
  end else begin : g_tk1_half
    assign w_k1[0] = {i_cnt, 64'h0};
  end

  for (genvar gi = 0; gi < numrnd; gi++) begin : g_round
    assign w_s[gi+1]  = round_state(w_s[gi], w_k1[gi] ^ w_k2[gi] ^ w_k3[gi], i_const[6*gi +: 6]);
    assign w_k1[gi+1] = tk_next(w_k1[gi], 1);
    assign w_k2[gi+1] = tk_next(w_k2[gi], 2);
    assign w_k3[gi+1] = tk_next(w_k3[gi], 3);
  end

  assign o_nextstate = w_s[numrnd];
  assign o_nextkey   = w_k3[numrnd];
  assign o_nexttweak = w_k2[numrnd];
  assign o_nextcnt   = w_k1[numrnd][127 -: 64+64*fullcnt];

endmodule

// File: rtl/skinny_tbc_iter.sv
// Iterative Skinny-128-384 TBC core: registers state and tweakey lanes, runs
// NUMRND rounds per clock through skinny_rnd and returns ct on valid/ready.
module skinny_tbc_iter
  import skinny_pkg::*;
#(
  parameter int NUMRND  = 2,
  parameter int TOTRND  = 40,
  parameter int FULLCNT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [127:0]              pt,
  input  logic [63+64*FULLCNT:0]    tk1,
  input  logic [127:0]              tk2,
  input  logic [127:0]              tk3,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [127:0]              ct
);

  localparam int ITER = iter_of(TOTRND, NUMRND);
  localparam int CW   = cnt_width(ITER);
  localparam int KW   = 64 + 64*FULLCNT;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  if (TOTRND % NUMRND != 0) begin : g_bad_cfg
    $error("skinny_tbc_iter: TOTRND must be a multiple of NUMRND");
  end

  fsm_state_t          r_fsm, w_fsm_next;
  logic [127:0]        r_state, r_tk2, r_tk3;
  logic [KW-1:0]       r_tk1;
  logic [5:0]          r_rc;
  logic [CW-1:0]       r_iter;

  logic [5:0]          w_rc_chain [NUMRND+1];
  logic [6*NUMRND-1:0] w_const;
  logic [127:0]        w_nstate, w_ntk2, w_ntk3;
  logic [KW-1:0]       w_ntk1;

  // r_rc holds the next round's constant; lane i carries the constant for round i of this cycle.
  assign w_rc_chain[0] = r_rc;
  for (genvar gi = 0; gi < NUMRND; gi++) begin : g_rc
    assign w_rc_chain[gi+1]   = rc_step(w_rc_chain[gi]);
    assign w_const[6*gi +: 6] = w_rc_chain[gi];
  end

  skinny_rnd #(
    .numrnd  (NUMRND),
    .fullcnt (FULLCNT)
  ) u_rnd (
    .i_state     (r_state),
    .i_key       (r_tk3),
    .i_tweak     (r_tk2),
    .i_cnt       (r_tk1),
    .i_const     (w_const),
    .o_nextstate (w_nstate),
    .o_nextkey   (w_ntk3),
    .o_nexttweak (w_ntk2),
    .o_nextcnt   (w_ntk1)
  );

  always_comb begin
    w_fsm_next = r_fsm;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    ct         = '0;
    case (r_fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_fsm_next = RUN;
      end
      RUN: begin
        if (r_iter == LAST) w_fsm_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        ct        = r_state;
        if (out_ready) w_fsm_next = IDLE;
      end
      default: w_fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm   <= IDLE;
      r_state <= '0;
      r_tk1   <= '0;
      r_tk2   <= '0;
      r_tk3   <= '0;
      r_rc    <= RC_INIT;
      r_iter  <= '0;
    end else begin
      r_fsm <= w_fsm_next;
      if (r_fsm == IDLE && in_valid) begin
        r_state <= pt;
        r_tk1   <= tk1;
        r_tk2   <= tk2;
        r_tk3   <= tk3;
        r_rc    <= RC_INIT;
        r_iter  <= '0;
      end else if (r_fsm == RUN) begin
        r_state <= w_nstate;
        r_tk1   <= w_ntk1;
        r_tk2   <= w_ntk2;
        r_tk3   <= w_ntk3;
        r_rc    <= w_rc_chain[NUMRND];
        if (r_iter != LAST) r_iter <= r_iter + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_skinny_tbc_iter.sv
// Scoreboard bench for skinny_tbc_iter: three configurations driven with the
// Skinny-128-384 reference vector, checked by per-instance output monitors.
module tb_skinny_tbc_iter;

  localparam logic [127:0] KTK1 = 128'hdf889548cfc7ea52d296339301797449;
  localparam logic [127:0] KTK2 = 128'hab588a34a47f1ab2dfe9c8293fbea9a5;
  localparam logic [127:0] KTK3 = 128'hab1afac2611012cd8cef952618c3ebe8;
  localparam logic [127:0] KPT  = 128'ha3994b66ad85a3459f44e92b08f550cb;
  localparam logic [127:0] KCT  = 128'h94ecf589e2017c601b38c6346a10dcfa;
  localparam int LAT_A = 29;
  localparam int LAT_B = 57;
  localparam int LAT_C = 21;

  typedef struct {
    logic [127:0] ct;
    int           lat;
    bit           chk_ct;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [127:0] pt, tk1, tk2, tk3;
  logic         iv_a, iv_b, iv_c, or_a, or_b, or_c;
  logic         ir_a, ir_b, ir_c, ov_a, ov_b, ov_c;
  logic [127:0] ct_a, ct_b, ct_c;

  skinny_tbc_iter #(.NUMRND(2), .TOTRND(56), .FULLCNT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a), .pt(pt), .tk1(tk1),
    .tk2(tk2), .tk3(tk3), .out_valid(ov_a), .out_ready(or_a), .ct(ct_a));
  skinny_tbc_iter #(.NUMRND(1), .TOTRND(56), .FULLCNT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .pt(pt), .tk1(tk1),
    .tk2(tk2), .tk3(tk3), .out_valid(ov_b), .out_ready(or_b), .ct(ct_b));
  skinny_tbc_iter #(.NUMRND(2), .TOTRND(40), .FULLCNT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_c), .in_ready(ir_c), .pt(pt), .tk1(tk1),
    .tk2(tk2), .tk3(tk3), .out_valid(ov_c), .out_ready(or_c), .ct(ct_c));

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  exp_t q_a[$], q_b[$], q_c[$];
  int   acc_a = 0, acc_b = 0, acc_c = 0;
  logic pv_a = 1'b0, pv_b = 1'b0, pv_c = 1'b0;

  always @(posedge clk) cyc++;

  function automatic void chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name, input string msg);
    n_checks++;
    n_err++;
    $display("FAIL %s: %s", name, msg);
  endfunction

  // Output monitors: latency on the rising edge of out_valid, ct on the handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) pv_a = 1'b0;
    else begin
      if (iv_a && ir_a) acc_a = cyc;
      if (ov_a && !pv_a) begin
        if (q_a.size() == 0) fail("A_spurious_valid", "out_valid with nothing pending");
        else chk_int("A_latency", cyc - acc_a, q_a[0].lat);
      end
      if (ov_a && or_a && q_a.size() > 0) begin
        e = q_a.pop_front();
        if (e.chk_ct) chk128("A_ct", ct_a, e.ct);
        $display("A out ct=%h lat=%0d", ct_a, cyc - acc_a);
      end
      pv_a = ov_a;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) pv_b = 1'b0;
    else begin
      if (iv_b && ir_b) acc_b = cyc;
      if (ov_b && !pv_b) begin
        if (q_b.size() == 0) fail("B_spurious_valid", "out_valid with nothing pending");
        else chk_int("B_latency", cyc - acc_b, q_b[0].lat);
      end
      if (ov_b && or_b && q_b.size() > 0) begin
        e = q_b.pop_front();
        if (e.chk_ct) chk128("B_ct", ct_b, e.ct);
        $display("B out ct=%h lat=%0d", ct_b, cyc - acc_b);
      end
      pv_b = ov_b;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) pv_c = 1'b0;
    else begin
      if (iv_c && ir_c) acc_c = cyc;
      if (ov_c && !pv_c) begin
        if (q_c.size() == 0) fail("C_spurious_valid", "out_valid with nothing pending");
        else chk_int("C_latency", cyc - acc_c, q_c[0].lat);
      end
      if (ov_c && or_c && q_c.size() > 0) begin
        e = q_c.pop_front();
        if (e.chk_ct) chk128("C_ct", ct_c, e.ct);
        $display("C out ct=%h lat=%0d", ct_c, cyc - acc_c);
      end
      pv_c = ov_c;
    end
  end

  function automatic logic ready_of(input int d);
    case (d)
      0:       return ir_a;
      1:       return ir_b;
      default: return ir_c;
    endcase
  endfunction

  function automatic int q_size(input int d);
    case (d)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q_a.delete();
    q_b.delete();
    q_c.delete();
  endtask

  // Issue the reference block to instance d and record what it must return.
  task automatic send(input int d, input int lat, input bit chkct);
    exp_t e;
    int   n;
    e.ct = KCT; e.lat = lat; e.chk_ct = chkct;
    pt = KPT; tk1 = KTK1; tk2 = KTK2; tk3 = KTK3;
    n = 0;
    while (!ready_of(d) && n < 200) begin
      tick();
      n++;
    end
    if (!ready_of(d)) fail("send_timeout", "in_ready never asserted");
    case (d)
      0:       begin q_a.push_back(e); iv_a = 1'b1; end
      1:       begin q_b.push_back(e); iv_b = 1'b1; end
      default: begin q_c.push_back(e); iv_c = 1'b1; end
    endcase
    tick();
    iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = 0;
    while (q_size(d) > 0 && n < 400) begin
      tick();
      n++;
    end
    if (q_size(d) > 0) begin
      fail("drain_timeout", "expected ct never handed over");
      q_a.delete(); q_b.delete(); q_c.delete();
    end
  endtask

  task automatic wait_ov_a();
    int n;
    n = 0;
    while (!ov_a && n < 200) begin
      tick();
      n++;
    end
    if (!ov_a) fail("A_valid_timeout", "out_valid never asserted");
  endtask

  initial begin
    rst_n = 1'b0;
    iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
    or_a = 1'b1; or_b = 1'b1; or_c = 1'b1;
    pt = KPT; tk1 = KTK1; tk2 = KTK2; tk3 = KTK3;
    tick();
    tick();
    do_reset();
    chk_int("rst_in_ready", int'(ir_a), 1);
    chk_int("rst_out_valid", int'(ov_a), 0);
    chk128("rst_ct", ct_a, 128'h0);
    chk_int("rst_rc", int'(dut_a.r_rc), 1);

    // Reference vector, two rounds per clock; constant lanes over the first RUN cycles.
    send(0, LAT_A, 1'b1);
    chk_int("run_in_ready", int'(ir_a), 0);
    chk_int("const_run1", int'(dut_a.w_const), int'({6'h03, 6'h01}));
    tick();
    chk_int("const_run2", int'(dut_a.w_const), int'({6'h0F, 6'h07}));
    tick();
    chk_int("const_run3", int'(dut_a.w_const), int'({6'h3E, 6'h1F}));
    wait_drain(0);
    chk_int("post_out_valid", int'(ov_a), 0);
    chk_int("post_in_ready", int'(ir_a), 1);

    // One round per clock gives the same ct; the 40-round variant is checked for latency.
    send(1, LAT_B, 1'b1);
    wait_drain(1);
    send(2, LAT_C, 1'b0);
    wait_drain(2);

    // Backpressure in DONE: output held, input pulses ignored.
    or_a = 1'b0;
    send(0, LAT_A, 1'b1);
    wait_ov_a();
    for (int i = 0; i < 10; i++) begin
      chk_int("hold_out_valid", int'(ov_a), 1);
      chk128("hold_ct", ct_a, KCT);
      chk_int("hold_in_ready", int'(ir_a), 0);
      pt   = ~KPT;
      iv_a = i[0];
      tick();
    end
    iv_a = 1'b0;
    pt   = KPT;
    or_a = 1'b1;
    tick();
    chk_int("release_out_valid", int'(ov_a), 0);
    chk_int("release_in_ready", int'(ir_a), 1);
    chk_int("release_popped", q_a.size(), 0);

    // A different block offered during RUN must not disturb the result.
    send(0, LAT_A, 1'b1);
    repeat (3) tick();
    pt   = ~KPT;
    iv_a = 1'b1;
    repeat (5) tick();
    iv_a = 1'b0;
    pt   = KPT;
    wait_drain(0);

    // Reset in the middle of RUN, then a fresh block.
    send(0, LAT_A, 1'b1);
    repeat (5) tick();
    do_reset();
    chk_int("rstrun_out_valid", int'(ov_a), 0);
    chk128("rstrun_ct", ct_a, 128'h0);
    chk_int("rstrun_in_ready", int'(ir_a), 1);
    send(0, LAT_A, 1'b1);
    wait_drain(0);

    // Reset while the result waits in DONE, then a fresh block.
    or_a = 1'b0;
    send(0, LAT_A, 1'b1);
    wait_ov_a();
    tick();
    do_reset();
    chk_int("rstdone_out_valid", int'(ov_a), 0);
    chk128("rstdone_ct", ct_a, 128'h0);
    chk_int("rstdone_in_ready", int'(ir_a), 1);
    or_a = 1'b1;
    send(0, LAT_A, 1'b1);
    wait_drain(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
